// File: rtl/scan_sequencer.sv
// Scan sequencer: steps a 2-to-4 decoder select through four slots, each slot an
// optional blanking interval followed by a drive interval with the enable high.
module scan_sequencer #(
    parameter int DWELL_W = 8,
    parameter int BLANK_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               one_shot,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [BLANK_W-1:0] blank,
    output logic               y0,
    output logic               y1,
    output logic               en,
    output logic               busy,
    output logic               frame_done
);

    localparam int CNT_W = (DWELL_W > BLANK_W) ? DWELL_W : BLANK_W;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    state_t             state;
    logic [1:0]         idx;
    logic [CNT_W-1:0]   cnt;
    logic [DWELL_W-1:0] dwell_q;
    logic [BLANK_W-1:0] blank_q;

    // Counters hold "cycles remaining minus one"; a zero dwell still gives one cycle.
    logic [CNT_W-1:0] dwell_load_in;
    logic [CNT_W-1:0] blank_load_in;
    logic [CNT_W-1:0] dwell_load_q;
    logic [CNT_W-1:0] blank_load_q;
    state_t           slot_state;
    logic [CNT_W-1:0] slot_cnt;
    logic             slot_en;

    assign dwell_load_in = (dwell == '0)   ? '0 : CNT_W'(dwell - DWELL_W'(1));
    assign blank_load_in = (blank == '0)   ? '0 : CNT_W'(blank - BLANK_W'(1));
    assign dwell_load_q  = (dwell_q == '0) ? '0 : CNT_W'(dwell_q - DWELL_W'(1));
    assign blank_load_q  = (blank_q == '0) ? '0 : CNT_W'(blank_q - BLANK_W'(1));

    assign slot_state = (blank_q != '0) ? BLANK : DRIVE;
    assign slot_cnt   = (blank_q != '0) ? blank_load_q : dwell_load_q;
    assign slot_en    = (blank_q == '0);

    assign y0 = idx[1];
    assign y1 = idx[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 2'd0;
            cnt        <= '0;
            dwell_q    <= '0;
            blank_q    <= '0;
            en         <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        dwell_q <= dwell;
                        blank_q <= blank;
                        idx     <= 2'd0;
                        busy    <= 1'b1;
                        if (blank != '0) begin
                            state <= BLANK;
                            cnt   <= blank_load_in;
                            en    <= 1'b0;
                        end else begin
                            state <= DRIVE;
                            cnt   <= dwell_load_in;
                            en    <= 1'b1;
                        end
                    end
                end
                BLANK: begin
                    if (stop) begin
                        state <= IDLE;
                        idx   <= 2'd0;
                        cnt   <= '0;
                        en    <= 1'b0;
                        busy  <= 1'b0;
                    end else if (cnt == '0) begin
                        state <= DRIVE;
                        cnt   <= dwell_load_q;
                        en    <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DRIVE: begin
                    if (stop) begin
                        state <= IDLE;
                        idx   <= 2'd0;
                        cnt   <= '0;
                        en    <= 1'b0;
                        busy  <= 1'b0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        // Slot finished: advance the select, wrapping at the end of the frame.
                        if (idx == 2'd3) begin
                            frame_done <= 1'b1;
                            idx        <= 2'd0;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                        if (idx == 2'd3 && one_shot) begin
                            state <= IDLE;
                            cnt   <= '0;
                            en    <= 1'b0;
                            busy  <= 1'b0;
                        end else begin
                            state <= slot_state;
                            cnt   <= slot_cnt;
                            en    <= slot_en;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    en    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against {y0,y1,en,busy,frame_done}.
module tb_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       one_shot;
    logic [7:0] dwell;
    logic [3:0] blank;
    logic       y0;
    logic       y1;
    logic       en;
    logic       busy;
    logic       frame_done;

    scan_sequencer #(.DWELL_W(8), .BLANK_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .one_shot   (one_shot),
        .dwell      (dwell),
        .blank      (blank),
        .y0         (y0),
        .y1         (y1),
        .en         (en),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [4:0] v;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checkCount = 0;
    int   passCount  = 0;

    task automatic checkOutput(input string name, input logic [4:0] actual, input logic [4:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got {y0,y1,en,busy,fd}=%b expected %b", name, actual, expected);
    endtask

    // Entries are tagged with the edge count after which they apply.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc < cyc) begin
                checkCount++;
                $display("[TB] FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
            end else begin
                checkOutput(e.name, {y0, y1, en, busy, frame_done}, e.v);
            end
        end
    end

    task automatic expectAt(input int c, input logic [1:0] idx, input logic e, input logic b,
                            input logic fd, input string name);
        exp_t x;
        x.cyc  = c;
        x.v    = {idx, e, b, fd};
        x.name = $sformatf("%s@%0d", name, c);
        q.push_back(x);
    endtask

    task automatic pushSlot(input int c0, input int s, input int b, input int d,
                            input string name, output int cNext);
        int c = c0;
        for (int i = 0; i < b; i++) begin
            expectAt(c, s[1:0], 1'b0, 1'b1, 1'b0, name);
            c++;
        end
        for (int i = 0; i < ((d == 0) ? 1 : d); i++) begin
            expectAt(c, s[1:0], 1'b1, 1'b1, 1'b0, name);
            c++;
        end
        cNext = c;
    endtask

    task automatic pushFrame(input int c0, input int b, input int d, input string name, output int cNext);
        int c = c0;
        for (int s = 0; s < 4; s++) pushSlot(c, s, b, d, name, c);
        cNext = c;
    endtask

    task automatic applyStimulus(input logic st, input logic sp, input logic os,
                                 input logic [7:0] dw, input logic [3:0] bl);
        start    = st;
        stop     = sp;
        one_shot = os;
        dwell    = dw;
        blank    = bl;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        int c;

        // Reset held two cycles with start high; start must be ignored.
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 4'd0);
        expectAt(1, 2'b00, 1'b0, 1'b0, 1'b0, "reset");
        expectAt(2, 2'b00, 1'b0, 1'b0, 1'b0, "reset");
        tick(2);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
        expectAt(3, 2'b00, 1'b0, 1'b0, 1'b0, "idle");
        expectAt(4, 2'b00, 1'b0, 1'b0, 1'b0, "idle");
        tick(2);

        // One-shot frame, dwell 3, blank 1: done pulse 17 cycles after the start cycle.
        n = cyc;
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd3, 4'd1);
        pushFrame(n + 1, 1, 3, "oneshot", c);
        expectAt(c, 2'b00, 1'b0, 1'b0, 1'b1, "oneshot_done");
        expectAt(c + 1, 2'b00, 1'b0, 1'b0, 1'b0, "oneshot_idle");
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd3, 4'd1);
        tick(c + 1 - cyc);

        // Zero dwell/blank continuous: select advances every cycle, then stop.
        n = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 4'd0);
        for (int k = 0; k < 10; k++)
            expectAt(n + 1 + k, k[1:0], 1'b1, 1'b1, (k >= 4 && (k % 4) == 0), "cont0");
        expectAt(n + 11, 2'b00, 1'b0, 1'b0, 1'b0, "cont0_stop");
        expectAt(n + 12, 2'b00, 1'b0, 1'b0, 1'b0, "cont0_idle");
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
        tick(9);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 4'd0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
        tick(1);

        // Continuous dwell 3; dwell changed to 7 mid-frame is ignored; stop in slot 2 drive.
        n = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd3, 4'd1);
        pushSlot(n + 1, 0, 1, 3, "dwchg", c);
        pushSlot(c, 1, 1, 3, "dwchg", c);
        expectAt(n + 9,  2'b10, 1'b0, 1'b1, 1'b0, "dwchg");
        expectAt(n + 10, 2'b10, 1'b1, 1'b1, 1'b0, "dwchg");
        expectAt(n + 11, 2'b10, 1'b1, 1'b1, 1'b0, "dwchg");
        expectAt(n + 12, 2'b00, 1'b0, 1'b0, 1'b0, "slot2_stop");
        expectAt(n + 13, 2'b00, 1'b0, 1'b0, 1'b0, "slot2_idle");
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd3, 4'd1);
        tick(2);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd7, 4'd1);
        tick(8);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd7, 4'd1);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd7, 4'd1);
        tick(1);

        // Restart picks up the new dwell of 7.
        n = cyc;
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd7, 4'd1);
        pushFrame(n + 1, 1, 7, "dwell7", c);
        expectAt(c, 2'b00, 1'b0, 1'b0, 1'b1, "dwell7_done");
        expectAt(c + 1, 2'b00, 1'b0, 1'b0, 1'b0, "dwell7_idle");
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd7, 4'd1);
        tick(c + 1 - cyc);

        // Start and stop together in idle: stop wins.
        n = cyc;
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd3, 4'd0);
        expectAt(n + 1, 2'b00, 1'b0, 1'b0, 1'b0, "start_stop");
        expectAt(n + 2, 2'b00, 1'b0, 1'b0, 1'b0, "start_stop");
        tick(2);

        // Reset in the middle of a drive interval.
        n = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd3, 4'd0);
        expectAt(n + 1, 2'b00, 1'b1, 1'b1, 1'b0, "pre_rst");
        expectAt(n + 2, 2'b00, 1'b1, 1'b1, 1'b0, "pre_rst");
        expectAt(n + 3, 2'b00, 1'b0, 1'b0, 1'b0, "rst_drive");
        expectAt(n + 4, 2'b00, 1'b0, 1'b0, 1'b0, "rst_idle");
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd3, 4'd0);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);

        // Start held high through a one-shot frame relaunches right after the done pulse.
        n = cyc;
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd1, 4'd0);
        for (int s = 0; s < 4; s++) expectAt(n + 1 + s, s[1:0], 1'b1, 1'b1, 1'b0, "held1");
        expectAt(n + 5, 2'b00, 1'b0, 1'b0, 1'b1, "held1_done");
        for (int s = 0; s < 4; s++) expectAt(n + 6 + s, s[1:0], 1'b1, 1'b1, 1'b0, "held2");
        expectAt(n + 10, 2'b00, 1'b0, 1'b0, 1'b1, "held2_done");
        expectAt(n + 11, 2'b00, 1'b0, 1'b0, 1'b0, "held2_idle");
        tick(6);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd1, 4'd0);
        tick(5);

        for (int i = 0; i < 20 && q.size() > 0; i++) tick(1);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checkCount++;
            $display("[TB] FAIL %s: expectation never sampled", e.name);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
